// File: rtl/alu_seq_exec.sv
// Multi-cycle RV32-style ALU: single-cycle ops finish in one cycle, shifts step
// one bit position per cycle through a working register and a down-counter.
module alu_seq_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [1:0]      dbg_state_o
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SW-1:0]   cnt_q, cnt_d;

    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] shifted;

    assign shamt    = operand_b[SW-1:0];
    assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

    // Shift ops only take this path when shamt is zero, so they pass operand_a.
    always_comb begin
        comb_res = operand_a + operand_b;
        case (alu_op)
            OP_SUB:  comb_res = operand_a - operand_b;
            OP_SLT:  comb_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_XOR:  comb_res = operand_a ^ operand_b;
            OP_OR:   comb_res = operand_a | operand_b;
            OP_AND:  comb_res = operand_a & operand_b;
            OP_SLL, OP_SRL, OP_SRA: comb_res = operand_a;
            default: comb_res = operand_a + operand_b;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
            default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = alu_op;
                    work_d = operand_a;
                    cnt_d  = shamt;
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d  = S_DONE;
                        result_d = comb_res;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_ONE;
                // Last step: publish the final shifted value as DONE is entered.
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = shifted;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign zero        = (result_q == '0);
    assign dbg_state_o = state_q;

endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; shift amount is operand_b[$clog2(XLEN)-1:0] (5 bits at 32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to execute; sampled only when busy=0.
REQ-005 alu_op  input  4  operation code, encoding per REQ-010.
REQ-006 operand_a  input  XLEN  first operand (rs1).
REQ-007 operand_b  input  XLEN  second operand (rs2 or immediate/shamt).
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle and held afterwards.
REQ-009a result  output  XLEN  registered result; zero  output  1  high when result == 0.

Function
REQ-010 Op encoding SHALL be: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND; 1010-1111 execute as ADD.
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; state encoding is free.
REQ-012 In IDLE with start=1 (cycle N): latch alu_op, operand_a, operand_b; go to SHIFT if op is SLL/SRL/SRA and shamt != 0, else DONE.
REQ-013 In IDLE with start=0: remain IDLE, outputs unchanged.
REQ-014 Non-shift ops and shifts with shamt=0: result computed from latched operands, done=1 at cycle N+1.
REQ-015 Shifts SHALL be iterative: one bit position per cycle in SHIFT, working register initialised to operand_a, down-counter initialised to shamt.
REQ-016 SHIFT -> DONE when counter reaches 0; shift by k (1..31) asserts done at cycle N+1+k.
REQ-017 SRA SHALL replicate bit XLEN-1 each step; SRL/SLL fill with 0.
REQ-018 Only operand_b[4:0] used for shifts; upper bits ignored.
REQ-019 ADD/SUB wrap modulo 2^XLEN; no overflow/carry output.
REQ-020 SLT signed compare, SLTU unsigned compare; result 32'h1 or 32'h0.
REQ-021 DONE lasts exactly one cycle, then IDLE unconditionally; done=1 only in DONE.
REQ-022 busy=1 in SHIFT and DONE; start while busy SHALL be ignored (not queued).
REQ-023 Next start accepted in the cycle after done (back-to-back throughput: one op per 2 cycles minimum).
REQ-024 result and zero SHALL update only in the cycle done rises and hold until the next done.
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, busy=0, done=0, result=0, zero=1, counter and latches cleared.
REQ-027 reset has priority over start and over any in-flight operation; aborted op produces no done pulse.
REQ-028 start asserted in the same cycle as reset SHALL be dropped.

Verification
REQ-029 ADD/SUB: a=32'h7FFFFFFF, b=1, op=0000 -> done at N+1, result=32'h80000000, zero=0; op=0001, a=5, b=5 -> result=0, zero=1.
REQ-030 SRA timing: a=32'h80000000, b=4, op=0111 -> busy N+1..N+5, done at N+5, result=32'hF8000000; op=0110 same operands -> 32'h08000000.
REQ-031 Shift edge: SLL a=1, b=32'hFFFFFFE0 (shamt 0) -> done at N+1, result=1; SLL a=1, b=31 -> done at N+32, result=32'h80000000.
REQ-032 Compare: a=32'hFFFFFFFF, b=1: SLT -> 1, SLTU -> 0; op=1100 with a=2, b=3 -> result=5.
REQ-033 Start while busy: second start pulsed mid-SHIFT with different operands -> ignored, single done with first result; next start after done accepted.
REQ-034 Reset mid-shift: SLL b=20, reset at N+6 -> busy=0, done never pulses, result=0, zero=1; subsequent XOR a=32'hF0F0F0F0, b=32'hFFFFFFFF -> 32'h0F0F0F0F at N+1.
